mouse_packet: RTL and testbench

Mouse packet assembler between the PS/2 byte transceiver and the mouse consumers (LED position tracker, cursor logic). After reset it enables mouse streaming mode, then assembles each standard 3-byte PS/2 mouse packet into signed 9-bit X/Y movement and 3 button bits. It pulses `m_done_tick` once per complete packet. Misaligned and stalled packets are dropped and flagged.

---
 rtl/mouse_pkg.sv | 28 ++
 rtl/mouse_byte_timer.sv | 33 +++
 rtl/mouse_packet.sv | 144 ++++++++++++++
 tb/tb_mouse_packet.sv | 278 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/mouse_pkg.sv
// Shared definitions for the PS/2 mouse packet assembler.
//   state_e : assembler FSM states
//   hdr_t   : fields kept from packet byte 1 (signs and buttons)
//   CMD_STREAM_EN / ACK_BYTE : init command byte and the mouse's acknowledge
//   SYNC_BIT : bit of byte 1 that is always 1 in a well-aligned packet
package mouse_pkg;

   typedef enum logic [2:0] {
      INIT_WR  = 3'd0,
      INIT_TX  = 3'd1,
      INIT_ACK = 3'd2,
      PACK1    = 3'd3,
      PACK2    = 3'd4,
      PACK3    = 3'd5,
      DONE     = 3'd6
   } state_e;

   localparam logic [7:0] CMD_STREAM_EN = 8'hF4;
   localparam logic [7:0] ACK_BYTE      = 8'hFA;
   localparam int unsigned SYNC_BIT     = 3;

   typedef struct packed {
      logic       y_sign;
      logic       x_sign;
      logic [2:0] btn;
   } hdr_t;

endpackage

// File: rtl/mouse_byte_timer.sv
// Inter-byte idle counter for the mouse packet assembler.
//   clk, reset : clock, async active-high reset
//   clear      : force the count to 0 (byte received or not inside a packet)
//   enable     : count this cycle as idle
//   expired    : count has reached TIMEOUT_CYCLES
module mouse_byte_timer #(
   parameter int unsigned TIMEOUT_CYCLES = 2_500_000
) (
   input  logic clk,
   input  logic reset,
   input  logic clear,
   input  logic enable,
   output logic expired
);

   localparam int unsigned CNT_W = $clog2(TIMEOUT_CYCLES + 1);
   localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(TIMEOUT_CYCLES);

   logic [CNT_W-1:0] count;

   // Saturates at the limit so it never wraps while the FSM reacts.
   always_ff @(posedge clk or posedge reset) begin
      if (reset)
         count <= '0;
      else if (clear)
         count <= '0;
      else if (enable && (count != CNT_MAX))
         count <= count + CNT_W'(1);
   end

   assign expired = (count == CNT_MAX);

endmodule

// File: rtl/mouse_packet.sv
// PS/2 mouse packet assembler: enables streaming mode after reset, then
// turns each 3-byte mouse packet into signed 9-bit X/Y and 3 button bits.
//   clk, reset             : clock, async active-high reset
//   rx_data, rx_done_tick  : received byte and its one-cycle strobe
//   tx_done_tick           : command byte has been sent
//   wr_ps2, tx_data        : one-cycle send request, command byte (F4)
//   xm, ym, btnm           : last decoded movement and buttons {M,R,L}
//   m_done_tick            : pulse, xm/ym/btnm just updated
//   init_done              : mouse acknowledged the streaming command
//   sync_err_tick          : pulse, a byte or partial packet was dropped
module mouse_packet
   import mouse_pkg::*;
#(
   parameter int unsigned TIMEOUT_CYCLES = 2_500_000
) (
   input  logic       clk,
   input  logic       reset,
   input  logic [7:0] rx_data,
   input  logic       rx_done_tick,
   input  logic       tx_done_tick,
   output logic       wr_ps2,
   output logic [7:0] tx_data,
   output logic [8:0] xm,
   output logic [8:0] ym,
   output logic [2:0] btnm,
   output logic       m_done_tick,
   output logic       init_done,
   output logic       sync_err_tick
);

   state_e     state_q, state_d;
   hdr_t       hdr_q, hdr_d;
   logic [7:0] b2_q, b2_d;
   logic [8:0] xm_d, ym_d;
   logic [2:0] btnm_d;
   logic       wr_d, m_done_d, init_d, sync_d;
   logic       in_pkt, expired;

   assign tx_data = CMD_STREAM_EN;

   // Idle timer only runs between bytes of a started packet.
   assign in_pkt = (state_q == PACK2) || (state_q == PACK3);

   mouse_byte_timer #(
      .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
   ) u_timer (
      .clk    (clk),
      .reset  (reset),
      .clear  (!in_pkt || rx_done_tick),
      .enable (in_pkt && !rx_done_tick),
      .expired(expired)
   );

   // Next state and next registered outputs. Outputs are loaded on the edge
   // that enters DONE so they are valid during the DONE cycle itself.
   always_comb begin
      state_d  = state_q;
      hdr_d    = hdr_q;
      b2_d     = b2_q;
      xm_d     = xm;
      ym_d     = ym;
      btnm_d   = btnm;
      wr_d     = 1'b0;
      m_done_d = 1'b0;
      init_d   = init_done;
      sync_d   = 1'b0;
      unique case (state_q)
         INIT_WR: begin
            wr_d    = 1'b1;
            state_d = INIT_TX;
         end
         INIT_TX: begin
            if (tx_done_tick)
               state_d = INIT_ACK;
         end
         INIT_ACK: begin
            if (rx_done_tick && (rx_data == ACK_BYTE)) begin
               init_d  = 1'b1;
               state_d = PACK1;
            end
         end
         PACK1, DONE: begin
            state_d = PACK1;
            if (rx_done_tick) begin
               if (!rx_data[SYNC_BIT]) begin
                  sync_d = 1'b1;
               end else begin
                  hdr_d   = '{y_sign: rx_data[5], x_sign: rx_data[4], btn: rx_data[2:0]};
                  state_d = PACK2;
               end
            end
         end
         PACK2: begin
            if (rx_done_tick) begin
               b2_d    = rx_data;
               state_d = PACK3;
            end else if (expired) begin
               sync_d  = 1'b1;
               state_d = PACK1;
            end
         end
         PACK3: begin
            if (rx_done_tick) begin
               xm_d     = {hdr_q.x_sign, b2_q};
               ym_d     = {hdr_q.y_sign, rx_data};
               btnm_d   = hdr_q.btn;
               m_done_d = 1'b1;
               state_d  = DONE;
            end else if (expired) begin
               sync_d  = 1'b1;
               state_d = PACK1;
            end
         end
         default: state_d = INIT_WR;
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q       <= INIT_WR;
         hdr_q         <= '0;
         b2_q          <= '0;
         xm            <= '0;
         ym            <= '0;
         btnm          <= '0;
         wr_ps2        <= 1'b0;
         m_done_tick   <= 1'b0;
         init_done     <= 1'b0;
         sync_err_tick <= 1'b0;
      end else begin
         state_q       <= state_d;
         hdr_q         <= hdr_d;
         b2_q          <= b2_d;
         xm            <= xm_d;
         ym            <= ym_d;
         btnm          <= btnm_d;
         wr_ps2        <= wr_d;
         m_done_tick   <= m_done_d;
         init_done     <= init_d;
         sync_err_tick <= sync_d;
      end
   end

endmodule

// File: tb/tb_mouse_packet.sv
// Directed bench for mouse_packet; outputs sampled on the falling edge.
module tb_mouse_packet;

   logic       clk = 1'b0;
   logic       reset;
   logic [7:0] rx_data;
   logic       rx_done_tick;
   logic       tx_done_tick;
   logic       wr_ps2;
   logic [7:0] tx_data;
   logic [8:0] xm;
   logic [8:0] ym;
   logic [2:0] btnm;
   logic       m_done_tick;
   logic       init_done;
   logic       sync_err_tick;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   mouse_packet #(.TIMEOUT_CYCLES(100)) dut (
      .clk          (clk),
      .reset        (reset),
      .rx_data      (rx_data),
      .rx_done_tick (rx_done_tick),
      .tx_done_tick (tx_done_tick),
      .wr_ps2       (wr_ps2),
      .tx_data      (tx_data),
      .xm           (xm),
      .ym           (ym),
      .btnm         (btnm),
      .m_done_tick  (m_done_tick),
      .init_done    (init_done),
      .sync_err_tick(sync_err_tick)
   );

   // Drive one byte strobe; returns on the falling edge after the capture edge.
   task automatic send_byte(input logic [7:0] b, input int gap);
      repeat (gap) @(negedge clk);
      @(negedge clk);
      rx_data      = b;
      rx_done_tick = 1'b1;
      @(negedge clk);
      rx_done_tick = 1'b0;
   endtask

   task automatic test_reset;
      reset        = 1'b1;
      rx_data      = 8'h00;
      rx_done_tick = 1'b0;
      tx_done_tick = 1'b0;
      repeat (3) @(negedge clk);
      checks++;
      if ({xm, ym, btnm} !== 21'd0) begin
         errors++;
         $display("FAIL reset_xyb got xm=%h ym=%h btnm=%b want 0", xm, ym, btnm);
      end
      checks++;
      if ({m_done_tick, wr_ps2, init_done, sync_err_tick} !== 4'b0000) begin
         errors++;
         $display("FAIL reset_flags got done=%b wr=%b init=%b sync=%b want 0",
                  m_done_tick, wr_ps2, init_done, sync_err_tick);
      end
      checks++;
      if (tx_data !== 8'hF4) begin
         errors++;
         $display("FAIL tx_data got %h want f4", tx_data);
      end
   endtask

   // Release reset and complete the init handshake, checking the wr pulse,
   // that bytes before tx_done and non-FA bytes are ignored.
   task automatic test_init(input string tag);
      int pulses;
      int first;
      pulses = 0;
      first  = -1;
      @(negedge clk);
      reset = 1'b0;
      for (int i = 0; i < 8; i++) begin
         @(negedge clk);
         if (wr_ps2 === 1'b1) begin
            pulses++;
            if (first < 0) first = i;
         end
         if (i == 3) begin
            rx_data      = 8'hFA;
            rx_done_tick = 1'b1;
         end else begin
            rx_done_tick = 1'b0;
         end
      end
      checks++;
      if (pulses != 1 || first != 0) begin
         errors++;
         $display("FAIL %s wr_pulse got pulses=%0d first=%0d want 1 at 0", tag, pulses, first);
      end
      checks++;
      if (init_done !== 1'b0) begin
         errors++;
         $display("FAIL %s ack_before_tx got init_done=%b want 0", tag, init_done);
      end
      tx_done_tick = 1'b1;
      @(negedge clk);
      tx_done_tick = 1'b0;
      send_byte(8'hFE, 2);
      checks++;
      if (init_done !== 1'b0) begin
         errors++;
         $display("FAIL %s non_ack got init_done=%b want 0", tag, init_done);
      end
      send_byte(8'hFA, 1);
      checks++;
      if (init_done !== 1'b1) begin
         errors++;
         $display("FAIL %s ack got init_done=%b want 1", tag, init_done);
      end
   endtask

   task automatic test_packets;
      logic [7:0] b [5][3];
      logic [8:0] ex [5];
      logic [8:0] ey [5];
      logic [2:0] eb [5];
      int         gap [5];
      b[0] = '{8'h08, 8'h05, 8'h03}; ex[0] = 9'h005; ey[0] = 9'h003; eb[0] = 3'b000; gap[0] = 0;
      b[1] = '{8'h39, 8'hFB, 8'hFE}; ex[1] = 9'h1FB; ey[1] = 9'h1FE; eb[1] = 3'b001; gap[1] = 2;
      b[2] = '{8'h2E, 8'h80, 8'h7F}; ex[2] = 9'h080; ey[2] = 9'h17F; eb[2] = 3'b110; gap[2] = 1;
      b[3] = '{8'hDC, 8'h01, 8'h02}; ex[3] = 9'h101; ey[3] = 9'h002; eb[3] = 3'b100; gap[3] = 60;
      b[4] = '{8'h18, 8'hFF, 8'h00}; ex[4] = 9'h1FF; ey[4] = 9'h000; eb[4] = 3'b000; gap[4] = 0;
      for (int p = 0; p < 5; p++) begin
         send_byte(b[p][0], 3);
         send_byte(b[p][1], gap[p]);
         checks++;
         if (m_done_tick !== 1'b0) begin
            errors++;
            $display("FAIL pkt%0d early_done got %b want 0", p, m_done_tick);
         end
         send_byte(b[p][2], gap[p]);
         checks++;
         if ({m_done_tick, xm, ym, btnm} !== {1'b1, ex[p], ey[p], eb[p]}) begin
            errors++;
            $display("FAIL pkt%0d decode got done=%b xm=%h ym=%h btnm=%b want done=1 xm=%h ym=%h btnm=%b",
                     p, m_done_tick, xm, ym, btnm, ex[p], ey[p], eb[p]);
         end
         repeat (2) @(negedge clk);
         checks++;
         if ({m_done_tick, xm, ym, btnm} !== {1'b0, ex[p], ey[p], eb[p]}) begin
            errors++;
            $display("FAIL pkt%0d hold got done=%b xm=%h ym=%h btnm=%b want done=0 xm=%h ym=%h btnm=%b",
                     p, m_done_tick, xm, ym, btnm, ex[p], ey[p], eb[p]);
         end
      end
   endtask

   task automatic test_sync;
      send_byte(8'h05, 2);
      checks++;
      if ({sync_err_tick, m_done_tick} !== 2'b10) begin
         errors++;
         $display("FAIL sync_err got sync=%b done=%b want sync=1 done=0", sync_err_tick, m_done_tick);
      end
      @(negedge clk);
      checks++;
      if (sync_err_tick !== 1'b0) begin
         errors++;
         $display("FAIL sync_pulse_width got %b want 0", sync_err_tick);
      end
      send_byte(8'h09, 0);
      send_byte(8'h10, 0);
      send_byte(8'h20, 0);
      checks++;
      if ({m_done_tick, xm, ym, btnm} !== {1'b1, 9'h010, 9'h020, 3'b001}) begin
         errors++;
         $display("FAIL sync_recover got done=%b xm=%h ym=%h btnm=%b want done=1 xm=010 ym=020 btnm=001",
                  m_done_tick, xm, ym, btnm);
      end
   endtask

   task automatic test_timeout;
      int err_at;
      int dones;
      err_at = -1;
      dones  = 0;
      send_byte(8'h08, 3);
      send_byte(8'h05, 0);
      for (int i = 1; i <= 130; i++) begin
         @(negedge clk);
         if (sync_err_tick === 1'b1 && err_at < 0) err_at = i;
         if (m_done_tick === 1'b1) dones++;
      end
      checks++;
      if (err_at < 100 || err_at > 102) begin
         errors++;
         $display("FAIL timeout_err got cycle %0d want 100..102", err_at);
      end
      checks++;
      if (dones != 0 || {xm, ym, btnm} !== {9'h010, 9'h020, 3'b001}) begin
         errors++;
         $display("FAIL timeout_no_done got dones=%0d xm=%h ym=%h btnm=%b want 0 010 020 001",
                  dones, xm, ym, btnm);
      end
      send_byte(8'h0A, 0);
      send_byte(8'h01, 0);
      send_byte(8'h01, 0);
      checks++;
      if ({m_done_tick, xm, ym, btnm} !== {1'b1, 9'h001, 9'h001, 3'b010}) begin
         errors++;
         $display("FAIL timeout_recover got done=%b xm=%h ym=%h btnm=%b want done=1 xm=001 ym=001 btnm=010",
                  m_done_tick, xm, ym, btnm);
      end
   endtask

   task automatic test_reset_mid;
      send_byte(8'h08, 2);
      send_byte(8'h05, 0);
      @(negedge clk);
      reset = 1'b1;
      @(negedge clk);
      checks++;
      if ({xm, ym, btnm, m_done_tick, wr_ps2, init_done, sync_err_tick} !== 25'd0) begin
         errors++;
         $display("FAIL reset_mid got xm=%h ym=%h btnm=%b done=%b wr=%b init=%b sync=%b want all 0",
                  xm, ym, btnm, m_done_tick, wr_ps2, init_done, sync_err_tick);
      end
      test_init("reinit");
   endtask

   task automatic test_back_to_back;
      @(negedge clk);
      rx_data = 8'h08; rx_done_tick = 1'b1;
      @(negedge clk);
      rx_data = 8'h05;
      @(negedge clk);
      rx_data = 8'h03;
      @(negedge clk);
      checks++;
      if ({m_done_tick, xm, ym, btnm} !== {1'b1, 9'h005, 9'h003, 3'b000}) begin
         errors++;
         $display("FAIL b2b_first got done=%b xm=%h ym=%h btnm=%b want done=1 xm=005 ym=003 btnm=000",
                  m_done_tick, xm, ym, btnm);
      end
      rx_data = 8'h39;
      @(negedge clk);
      checks++;
      if (m_done_tick !== 1'b0) begin
         errors++;
         $display("FAIL b2b_gap got done=%b want 0", m_done_tick);
      end
      rx_data = 8'hFB;
      @(negedge clk);
      rx_data = 8'hFE;
      @(negedge clk);
      rx_done_tick = 1'b0;
      checks++;
      if ({m_done_tick, xm, ym, btnm} !== {1'b1, 9'h1FB, 9'h1FE, 3'b001}) begin
         errors++;
         $display("FAIL b2b_second got done=%b xm=%h ym=%h btnm=%b want done=1 xm=1fb ym=1fe btnm=001",
                  m_done_tick, xm, ym, btnm);
      end
   endtask

   initial begin
      test_reset();
      test_init("init");
      test_packets();
      test_sync();
      test_timeout();
      test_reset_mid();
      test_back_to_back();
      repeat (3) @(negedge clk);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
